// File: rtl/spi_slave_mode_if.sv
// SPI pin bundle plus TX handshake and regfile strobes for spi_slave_mode.
// The slave modport is the DUT view; the master modport is the driving side.
interface spi_slave_mode_if #(
    parameter int FRAME_NBITS = 32,
    parameter int CMD_NBITS   = 8
);
    logic                   i_sclk;
    logic                   i_ssn;
    logic                   i_mosi;
    logic                   i_tx_valid;
    logic [FRAME_NBITS-1:0] i_tx_data;
    logic                   o_tx_ready;
    logic                   o_miso;
    logic                   o_miso_oe;
    logic                   o_cmd_valid;
    logic [CMD_NBITS-1:0]   o_cmd;
    logic                   o_rx_valid;
    logic [FRAME_NBITS-1:0] o_rx_data;
    logic                   o_frame_active;
    logic                   o_frame_err;
    logic                   o_tx_underrun;

    modport slave (
        input  i_sclk, i_ssn, i_mosi, i_tx_valid, i_tx_data,
        output o_tx_ready, o_miso, o_miso_oe, o_cmd_valid, o_cmd,
               o_rx_valid, o_rx_data, o_frame_active, o_frame_err, o_tx_underrun
    );

    modport master (
        output i_sclk, i_ssn, i_mosi, i_tx_valid, i_tx_data,
        input  o_tx_ready, o_miso, o_miso_oe, o_cmd_valid, o_cmd,
               o_rx_valid, o_rx_data, o_frame_active, o_frame_err, o_tx_underrun
    );
endinterface

// File: rtl/spi_slave_mode.sv
// Oversampled SPI slave, any CPOL/CPHA, burst words under one SSN, with a
// double-buffered TX path and command/word strobes toward the register file.
module spi_slave_mode #(
    parameter int FRAME_NBITS = 32,
    parameter int CMD_NBITS   = 8,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input logic            i_clk,
    input logic            i_rst,
    spi_slave_mode_if.slave bus
);

    localparam int CNT_W = $clog2(FRAME_NBITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_NBITS - 1);
    localparam logic [CNT_W-1:0] CMD_BIT  = CNT_W'(CMD_NBITS - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, ssn_sync, mosi_sync;
    logic                   ssn_level;

    logic [FRAME_NBITS-1:0] holding, tx_sh, rx_sh, rx_data;
    logic                   holding_full;
    logic [CNT_W-1:0]       cnt;
    logic [CMD_NBITS-1:0]   cmd;
    logic                   miso_q;
    logic                   cmd_valid, rx_valid, frame_err, tx_underrun;

    // Synchronisers: bit 0 is newest, bit SYNC_STAGES-1 oldest.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sclk_sync <= {SYNC_STAGES{CPOL}};
            ssn_sync  <= '1;
            mosi_sync <= '0;
        end else begin
            // NOTE: every sequential assignment is non-blocking so all flops
            // update from pre-edge values and the chain shifts one stage per clock.
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.i_sclk};
            ssn_sync  <= {ssn_sync[SYNC_STAGES-2:0], bus.i_ssn};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.i_mosi};
        end
    end

    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
    logic ssn_fall, ssn_rise, mosi_bit;

    assign sclk_rise   = sclk_sync[SYNC_STAGES-2] & ~sclk_sync[SYNC_STAGES-1];
    assign sclk_fall   = ~sclk_sync[SYNC_STAGES-2] & sclk_sync[SYNC_STAGES-1];
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign mosi_bit    = mosi_sync[SYNC_STAGES-1];

    // SSN only changes level once every sync stage agrees, so a pulse shorter
    // than the synchroniser window never opens or closes a frame.
    assign ssn_fall = ssn_level & (ssn_sync == '0);
    assign ssn_rise = ~ssn_level & (&ssn_sync);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ssn_level <= 1'b1;
            state     <= IDLE;
        end else begin
            if (ssn_fall) ssn_level <= 1'b0;
            else if (ssn_rise) ssn_level <= 1'b1;
            state <= state_next;
        end
    end

    logic edge_en, sample_en, shift_en, word_done, cmd_done, word_start, tx_write;
    logic [FRAME_NBITS-1:0] rx_next, load_word;

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        state_next = state;
        edge_en    = 1'b0;
        word_start = 1'b0;
        unique case (state)
            IDLE: begin
                if (ssn_fall) begin
                    state_next = ACTIVE;
                    word_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (ssn_rise) state_next = IDLE;
                else edge_en = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        if (edge_en && sample_edge && cnt == LAST_BIT) word_start = 1'b1;
    end

    assign sample_en = edge_en & sample_edge;
    assign shift_en  = edge_en & shift_edge;
    assign word_done = sample_en && (cnt == LAST_BIT);
    assign cmd_done  = sample_en && (cnt == CMD_BIT);
    assign rx_next   = {rx_sh[FRAME_NBITS-2:0], mosi_bit};
    assign tx_write  = bus.i_tx_valid & ~holding_full;
    assign load_word = holding_full ? holding : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the whole datapath is cleared on reset so the outputs and
            // the next frame never see stale shift-register or holding contents.
            holding      <= '0;
            holding_full <= 1'b0;
            tx_sh        <= '0;
            rx_sh        <= '0;
            rx_data      <= '0;
            cnt          <= '0;
            cmd          <= '0;
            miso_q       <= 1'b0;
            cmd_valid    <= 1'b0;
            rx_valid     <= 1'b0;
            frame_err    <= 1'b0;
            tx_underrun  <= 1'b0;
        end else begin
            cmd_valid   <= 1'b0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;

            if (tx_write) holding <= bus.i_tx_data;
            if (word_start) holding_full <= tx_write;
            else if (tx_write) holding_full <= 1'b1;

            // A word start consumes the old holding content; a same-cycle write
            // lands behind it for the following word.
            if (word_start) begin
                tx_underrun <= ~holding_full;
                if (!CPHA && state == IDLE) begin
                    miso_q <= load_word[FRAME_NBITS-1];
                    tx_sh  <= {load_word[FRAME_NBITS-2:0], 1'b0};
                end else begin
                    tx_sh <= load_word;
                end
            end else if (shift_en) begin
                miso_q <= tx_sh[FRAME_NBITS-1];
                tx_sh  <= {tx_sh[FRAME_NBITS-2:0], 1'b0};
            end

            if (sample_en) begin
                rx_sh <= rx_next;
                if (cmd_done) begin
                    cmd       <= rx_next[CMD_NBITS-1:0];
                    cmd_valid <= 1'b1;
                end
                if (word_done) begin
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            // Frame closed: drop any partial word and flag it if bits were lost.
            if (state == ACTIVE && ssn_rise) begin
                frame_err <= (cnt != '0);
                cnt       <= '0;
                rx_sh     <= '0;
                miso_q    <= 1'b0;
            end
        end
    end

    assign bus.o_tx_ready     = ~holding_full;
    assign bus.o_frame_active = (state == ACTIVE);
    assign bus.o_miso_oe      = (state == ACTIVE);
    assign bus.o_miso         = miso_q & (state == ACTIVE);
    assign bus.o_cmd_valid    = cmd_valid;
    assign bus.o_cmd          = cmd;
    assign bus.o_rx_valid     = rx_valid;
    assign bus.o_rx_data      = rx_data;
    assign bus.o_frame_err    = frame_err;
    assign bus.o_tx_underrun  = tx_underrun;

endmodule

// File: tb/tb_spi_slave_mode.sv
// Scoreboard bench for spi_slave_mode: one instance per SPI mode, a bit-banged
// master drives the selected instance, a monitor pops expected cmd/rx words.
module tb_spi_slave_mode;

    localparam int FN   = 32;
    localparam int CN   = 8;
    localparam int HALF = 8;   // i_clk cycles per SCLK half period

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sclk_v[4], ssn_v[4], mosi_v[4], txv_v[4];
    logic [31:0] txd_v[4];
    logic        rdy_w[4], miso_w[4], oe_w[4], cmdv_w[4], rxv_w[4];
    logic        act_w[4], err_w[4], und_w[4];
    logic [7:0]  cmd_w[4];
    logic [31:0] rxd_w[4];

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_slave_mode_if #(.FRAME_NBITS(FN), .CMD_NBITS(CN)) bus ();
        assign bus.i_sclk     = sclk_v[g];
        assign bus.i_ssn      = ssn_v[g];
        assign bus.i_mosi     = mosi_v[g];
        assign bus.i_tx_valid = txv_v[g];
        assign bus.i_tx_data  = txd_v[g];
        spi_slave_mode #(
            .FRAME_NBITS(FN), .CMD_NBITS(CN),
            .CPOL(1'(g / 2)), .CPHA(1'(g % 2)), .SYNC_STAGES(2)
        ) dut (
            .i_clk(clk),
            .i_rst(rst),
            .bus  (bus.slave)
        );
        assign rdy_w[g]  = bus.o_tx_ready;
        assign miso_w[g] = bus.o_miso;
        assign oe_w[g]   = bus.o_miso_oe;
        assign cmdv_w[g] = bus.o_cmd_valid;
        assign cmd_w[g]  = bus.o_cmd;
        assign rxv_w[g]  = bus.o_rx_valid;
        assign rxd_w[g]  = bus.o_rx_data;
        assign act_w[g]  = bus.o_frame_active;
        assign err_w[g]  = bus.o_frame_err;
        assign und_w[g]  = bus.o_tx_underrun;
    end

    int checks = 0;
    int failures = 0;
    int cur = 0;
    int und_cnt = 0, err_cnt = 0, act_cyc = 0;
    logic [7:0]  exp_cmd_q[$];
    logic [31:0] exp_rx_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe of the selected instance is matched against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (cmdv_w[cur]) begin
                if (exp_cmd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL cmd_unexpected actual=0x%0h required=no_pulse", cmd_w[cur]);
                end else begin
                    check("cmd", 64'(cmd_w[cur]), 64'(exp_cmd_q.pop_front()));
                end
            end
            if (rxv_w[cur]) begin
                if (exp_rx_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected actual=0x%0h required=no_pulse", rxd_w[cur]);
                end else begin
                    check("rx_data", 64'(rxd_w[cur]), 64'(exp_rx_q.pop_front()));
                end
            end
            if (und_w[cur]) und_cnt++;
            if (err_w[cur]) err_cnt++;
            if (act_w[cur]) act_cyc++;
        end
    end

    task automatic half_bit();
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    task automatic write_tx(input int m, input logic [31:0] d);
        int n = 0;
        @(posedge clk);
        #1;
        txv_v[m] = 1'b1;
        txd_v[m] = d;
        forever begin
            @(negedge clk);
            if (rdy_w[m]) break;
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL tx_ready_timeout actual=0 required=1");
                break;
            end
        end
        @(posedge clk);
        #1;
        txv_v[m] = 1'b0;
    endtask

    // Clocks nbits of data (MSB first) and returns the MISO bits the master sampled.
    task automatic spi_bits(input int m, input logic [31:0] data, input int nbits,
                            output logic [31:0] rd);
        rd = '0;
        for (int i = 0; i < nbits; i++) begin
            if (m % 2 == 0) begin
                mosi_v[m] = data[31-i];
                half_bit();
                sclk_v[m] = ~sclk_v[m];
                rd = {rd[30:0], miso_w[m]};
                half_bit();
                sclk_v[m] = ~sclk_v[m];
            end else begin
                sclk_v[m] = ~sclk_v[m];
                mosi_v[m] = data[31-i];
                half_bit();
                sclk_v[m] = ~sclk_v[m];
                rd = {rd[30:0], miso_w[m]};
                half_bit();
            end
        end
    endtask

    task automatic ssn_low(input int m);
        ssn_v[m] = 1'b0;
        half_bit();
        half_bit();
    endtask

    task automatic ssn_high(input int m);
        half_bit();
        ssn_v[m] = 1'b1;
        repeat (4) half_bit();
    endtask

    initial begin
        logic [31:0] rd, rd2;
        int u0, e0, a0;

        for (int m = 0; m < 4; m++) begin
            sclk_v[m] = (m >= 2);
            ssn_v[m]  = 1'b1;
            mosi_v[m] = 1'b0;
            txv_v[m]  = 1'b0;
            txd_v[m]  = '0;
        end
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int m = 0; m < 4; m++) check("reset_tx_ready", 64'(rdy_w[m]), 64'd1);
        check("reset_frame_active", 64'(act_w[0]), 64'd0);
        check("reset_miso_oe", 64'(oe_w[0]), 64'd0);
        check("reset_miso", 64'(miso_w[0]), 64'd0);
        check("reset_rx_data", 64'(rxd_w[0]), 64'd0);
        check("reset_cmd", 64'(cmd_w[0]), 64'd0);

        // Same word in every mode; the only underrun is the reload at word completion.
        for (int m = 0; m < 4; m++) begin
            cur = m;
            write_tx(m, 32'hA5A5_1234);
            exp_cmd_q.push_back(8'h0F);
            exp_rx_q.push_back(32'h0F00_BEEF);
            u0 = und_cnt;
            e0 = err_cnt;
            ssn_low(m);
            check("frame_active", 64'(act_w[m]), 64'd1);
            check("miso_oe", 64'(oe_w[m]), 64'd1);
            spi_bits(m, 32'h0F00_BEEF, 32, rd);
            ssn_high(m);
            check("miso_word", 64'(rd), 64'hA5A5_1234);
            check("underrun_count", 64'(und_cnt - u0), 64'd1);
            check("frame_err_count", 64'(err_cnt - e0), 64'd0);
            check("idle_frame_active", 64'(act_w[m]), 64'd0);
            check("idle_tx_ready", 64'(rdy_w[m]), 64'd1);
        end

        // Two-word burst, second TX word written once the first is consumed.
        cur = 0;
        write_tx(0, 32'h1111_1111);
        exp_cmd_q.push_back(8'hAB);
        exp_rx_q.push_back(32'hAB00_0001);
        exp_cmd_q.push_back(8'hCD);
        exp_rx_q.push_back(32'hCD00_0002);
        u0 = und_cnt;
        ssn_v[0] = 1'b0;
        write_tx(0, 32'h2222_2222);
        half_bit();
        half_bit();
        spi_bits(0, 32'hAB00_0001, 32, rd);
        spi_bits(0, 32'hCD00_0002, 32, rd2);
        ssn_high(0);
        check("burst_miso_word0", 64'(rd), 64'h1111_1111);
        check("burst_miso_word1", 64'(rd2), 64'h2222_2222);
        check("burst_underrun_count", 64'(und_cnt - u0), 64'd1);

        // Nothing written: underrun at SSN fall and again at word completion.
        u0 = und_cnt;
        exp_cmd_q.push_back(8'h3C);
        exp_rx_q.push_back(32'h3C5A_9600);
        ssn_low(0);
        check("underrun_at_ssn_fall", 64'(und_cnt - u0), 64'd1);
        spi_bits(0, 32'h3C5A_9600, 32, rd);
        ssn_high(0);
        check("underrun_miso_word", 64'(rd), 64'd0);
        check("underrun_total", 64'(und_cnt - u0), 64'd2);

        // 13-bit frame: command strobe stands, no word, one frame error.
        write_tx(0, 32'h55AA_55AA);
        exp_cmd_q.push_back(8'h0F);
        e0 = err_cnt;
        ssn_low(0);
        spi_bits(0, 32'h0F00_BEEF, 13, rd);
        ssn_high(0);
        check("partial_frame_err", 64'(err_cnt - e0), 64'd1);
        check("partial_miso_bits", 64'(rd), 64'(32'h55AA_55AA >> 19));
        write_tx(0, 32'hCAFE_F00D);
        exp_cmd_q.push_back(8'h12);
        exp_rx_q.push_back(32'h1234_5678);
        e0 = err_cnt;
        ssn_low(0);
        spi_bits(0, 32'h1234_5678, 32, rd);
        ssn_high(0);
        check("after_partial_miso", 64'(rd), 64'hCAFE_F00D);
        check("after_partial_no_err", 64'(err_cnt - e0), 64'd0);

        // One-cycle SSN glitch must not open a frame.
        a0 = act_cyc;
        u0 = und_cnt;
        @(posedge clk);
        #1;
        ssn_v[0] = 1'b0;
        @(posedge clk);
        #1;
        ssn_v[0] = 1'b1;
        repeat (12) @(posedge clk);
        check("glitch_no_frame", 64'(act_cyc - a0), 64'd0);
        check("glitch_no_underrun", 64'(und_cnt - u0), 64'd0);

        // Reset at bit 20 while SSN is low; master releases the bus during reset.
        write_tx(0, 32'hDEAD_BEEF);
        exp_cmd_q.push_back(8'h0F);
        e0 = err_cnt;
        ssn_low(0);
        spi_bits(0, 32'h0F00_BEEF, 20, rd);
        rst = 1'b1;
        ssn_v[0] = 1'b1;
        sclk_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_frame_active", 64'(act_w[0]), 64'd0);
        check("rst_tx_ready", 64'(rdy_w[0]), 64'd1);
        check("rst_miso_oe", 64'(oe_w[0]), 64'd0);
        check("rst_miso", 64'(miso_w[0]), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) half_bit();
        check("rst_no_frame_err", 64'(err_cnt - e0), 64'd0);
        write_tx(0, 32'h600D_F00D);
        exp_cmd_q.push_back(8'h9A);
        exp_rx_q.push_back(32'h9ABC_DEF0);
        ssn_low(0);
        spi_bits(0, 32'h9ABC_DEF0, 32, rd);
        ssn_high(0);
        check("after_rst_miso", 64'(rd), 64'h600D_F00D);

        repeat (20) @(posedge clk);
        check("cmd_queue_drained", 64'(exp_cmd_q.size()), 64'd0);
        check("rx_queue_drained", 64'(exp_rx_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
